// File: rtl/seq_lock_pkg.sv
// Shared types and defaults for the seq_lock combination lock: state encoding,
// default parameters, and a helper that extracts one digit from a packed code.
package seq_lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_CHANGE  = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_ALARM   = 3'd4
  } state_t;

  localparam int DEF_DIGIT_W        = 4;
  localparam int DEF_NUM_DIGITS     = 3;
  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_LOCKOUT_CYCLES = 100;
  localparam int DEF_RELOCK_CYCLES  = 500;
  localparam logic [DEF_NUM_DIGITS*DEF_DIGIT_W-1:0] DEF_CODE = {3{4'h6}};

  // Widest code / digit the helper handles; callers zero-extend and truncate.
  localparam int MAX_CODE_W  = 64;
  localparam int MAX_DIGIT_W = 16;

  function automatic logic [MAX_DIGIT_W-1:0] code_digit(
    input logic [MAX_CODE_W-1:0] code,
    input int                    idx,
    input int                    dw
  );
    logic [MAX_CODE_W-1:0]  sh;
    logic [MAX_DIGIT_W-1:0] mask;
    sh   = code >> (idx * dw);
    mask = (MAX_DIGIT_W'(1) << dw) - MAX_DIGIT_W'(1);
    return sh[MAX_DIGIT_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/seq_lock_code_store.sv
// Code store: live code plus shadow register, combinational read at idx, one-cycle commit.
// Commit copies the shadow including a digit written in the same cycle; reset restores DEFAULT_CODE.
module code_store
  import seq_lock_pkg::*;
#(
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = DEF_CODE
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [$clog2(NUM_DIGITS)-1:0] idx,
  output logic [DIGIT_W-1:0]            rd_digit,
  input  logic                          shadow_we,
  input  logic [DIGIT_W-1:0]            wr_digit,
  input  logic                          commit
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int CODE_W = NUM_DIGITS * DIGIT_W;

  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] shadow_q;
  logic [CODE_W-1:0] shadow_nxt;

  always_comb begin
    shadow_nxt = shadow_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (shadow_we && (idx == IDX_W'(i))) begin
        shadow_nxt[i*DIGIT_W +: DIGIT_W] = wr_digit;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      code_q   <= DEFAULT_CODE;
      shadow_q <= DEFAULT_CODE;
    end else begin
      shadow_q <= shadow_nxt;
      if (commit) begin
        code_q <= shadow_nxt;
      end
    end
  end

  assign rd_digit = DIGIT_W'(code_digit(MAX_CODE_W'(code_q), int'(idx), DIGIT_W));

endmodule

// File: rtl/seq_lock.sv
// Multi-digit combination lock with timed lockout, sticky alarm and in-place code change; outputs
// registered, visible 1 cycle after a strobe; no backpressure (strobes dropped in LOCKOUT/ALARM). SEQ_LOCK_AUTO_RELOCK_EN adds OPEN timeout.
module seq_lock
  import seq_lock_pkg::*;
#(
  parameter int DIGIT_W        = DEF_DIGIT_W,
  parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = DEF_CODE,
  parameter int RELOCK_CYCLES  = DEF_RELOCK_CYCLES
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [DIGIT_W-1:0]             digit,
  input  logic                           enter_pulse,
  input  logic                           change_pulse,
  output logic                           open,
  output logic                           new_code,
  output logic                           alarm,
  output logic                           locked_out,
  output logic [$clog2(NUM_DIGITS)-1:0]  digit_idx,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int FC_W  = $clog2(MAX_FAILS + 1);
  localparam int LK_W  = $clog2(LOCKOUT_CYCLES + 1);

  state_t            state;
  logic              mismatch_q;
  logic [LK_W-1:0]   lock_cnt;
  logic [DIGIT_W-1:0] code_digit_rd;
  logic              enter_only;
  logic              change_only;
  logic              last_digit;
  logic              digit_bad;
  logic              shadow_we;
  logic              commit;
`ifdef SEQ_LOCK_AUTO_RELOCK_EN
  localparam int RL_W = $clog2(RELOCK_CYCLES + 1);
  logic [RL_W-1:0]   relock_cnt;
`endif

  // Simultaneous strobes are treated as noise everywhere.
  assign enter_only  = enter_pulse & ~change_pulse;
  assign change_only = change_pulse & ~enter_pulse;
  assign last_digit  = (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign digit_bad   = (digit != code_digit_rd);
  assign shadow_we   = (state == ST_CHANGE) && enter_only;
  assign commit      = shadow_we && last_digit;

  code_store #(
    .DIGIT_W      (DIGIT_W),
    .NUM_DIGITS   (NUM_DIGITS),
    .DEFAULT_CODE (DEFAULT_CODE)
  ) u_code_store (
    .clock     (clock),
    .reset     (reset),
    .idx       (digit_idx),
    .rd_digit  (code_digit_rd),
    .shadow_we (shadow_we),
    .wr_digit  (digit),
    .commit    (commit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_ENTRY;
      open       <= 1'b0;
      new_code   <= 1'b0;
      alarm      <= 1'b0;
      locked_out <= 1'b0;
      digit_idx  <= '0;
      fail_count <= '0;
      mismatch_q <= 1'b0;
      lock_cnt   <= '0;
`ifdef SEQ_LOCK_AUTO_RELOCK_EN
      relock_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_ENTRY: begin
          if (enter_only) begin
            if (last_digit) begin
              digit_idx  <= '0;
              mismatch_q <= 1'b0;
              if (!(mismatch_q || digit_bad)) begin
                state      <= ST_OPEN;
                open       <= 1'b1;
                fail_count <= '0;
`ifdef SEQ_LOCK_AUTO_RELOCK_EN
                relock_cnt <= RL_W'(RELOCK_CYCLES - 1);
`endif
              end else if (fail_count == FC_W'(MAX_FAILS - 1)) begin
                state      <= ST_ALARM;
                alarm      <= 1'b1;
                fail_count <= FC_W'(MAX_FAILS);
              end else begin
                state      <= ST_LOCKOUT;
                locked_out <= 1'b1;
                fail_count <= fail_count + 1'b1;
                lock_cnt   <= LK_W'(LOCKOUT_CYCLES - 1);
              end
            end else begin
              digit_idx  <= digit_idx + 1'b1;
              mismatch_q <= mismatch_q | digit_bad;
            end
          end else if (change_only) begin
            digit_idx  <= '0;
            mismatch_q <= 1'b0;
          end
        end

        ST_LOCKOUT: begin
          if (lock_cnt == '0) begin
            state      <= ST_ENTRY;
            locked_out <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end

        ST_OPEN: begin
          if (enter_only) begin
            state <= ST_ENTRY;
            open  <= 1'b0;
          end else if (change_only) begin
            state     <= ST_CHANGE;
            open      <= 1'b0;
            new_code  <= 1'b1;
            digit_idx <= '0;
          end
`ifdef SEQ_LOCK_AUTO_RELOCK_EN
          // Only a simultaneous strobe reaches here while still open; it just rearms the timer.
          else if (enter_pulse || change_pulse) begin
            relock_cnt <= RL_W'(RELOCK_CYCLES - 1);
          end else if (relock_cnt == '0) begin
            state <= ST_ENTRY;
            open  <= 1'b0;
          end else begin
            relock_cnt <= relock_cnt - 1'b1;
          end
`endif
        end

        ST_CHANGE: begin
          if (enter_only) begin
            if (last_digit) begin
              state     <= ST_ENTRY;
              new_code  <= 1'b0;
              digit_idx <= '0;
            end else begin
              digit_idx <= digit_idx + 1'b1;
            end
          end else if (change_only) begin
            state     <= ST_ENTRY;
            new_code  <= 1'b0;
            digit_idx <= '0;
          end
        end

        ST_ALARM: begin
          state <= ST_ALARM;
        end

        default: begin
          state      <= ST_ENTRY;
          open       <= 1'b0;
          new_code   <= 1'b0;
          alarm      <= 1'b0;
          locked_out <= 1'b0;
          digit_idx  <= '0;
          mismatch_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_lock.sv
// Bench for seq_lock: directed scenarios plus random strobes against a queue-based model of the lock.
module tb_seq_lock;

  localparam int ND = 3;
  localparam int MF = 3;
  localparam int LK = 100;
  localparam int RL = 500;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit = '0;
  logic       enter_pulse = 1'b0;
  logic       change_pulse = 1'b0;
  logic       open, new_code, alarm, locked_out;
  logic [1:0] digit_idx, fail_count;

  int errors = 0;
  int checks = 0;

  // Model: entered digits kept as a queue and compared as a whole sequence.
  bit m_open, m_new, m_alarm;
  int m_lock, m_relock, m_fails;
  int m_code[ND];
  int m_entry[$];
  int m_shadow[$];

  seq_lock dut (
    .clock        (clock),
    .reset        (reset),
    .digit        (digit),
    .enter_pulse  (enter_pulse),
    .change_pulse (change_pulse),
    .open         (open),
    .new_code     (new_code),
    .alarm        (alarm),
    .locked_out   (locked_out),
    .digit_idx    (digit_idx),
    .fail_count   (fail_count)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_open = 0; m_new = 0; m_alarm = 0;
    m_lock = 0; m_relock = 0; m_fails = 0;
    for (int i = 0; i < ND; i++) m_code[i] = 6;
    m_entry.delete();
    m_shadow.delete();
  endfunction

  function automatic void model_step(input bit en, input bit ch, input int d);
    bit e, c, ok;
    e = en && !ch;
    c = ch && !en;
    if (m_alarm) return;
    if (m_lock > 0) begin
      m_lock--;
      return;
    end
    if (m_open) begin
`ifdef SEQ_LOCK_AUTO_RELOCK_EN
      if (en || ch) m_relock = RL;
      else begin
        m_relock--;
        if (m_relock == 0) m_open = 0;
      end
`endif
      if (e) m_open = 0;
      else if (c) begin
        m_open = 0;
        m_new = 1;
        m_shadow.delete();
      end
      return;
    end
    if (m_new) begin
      if (e) begin
        m_shadow.push_back(d);
        if (m_shadow.size() == ND) begin
          for (int i = 0; i < ND; i++) m_code[i] = m_shadow[i];
          m_shadow.delete();
          m_new = 0;
        end
      end else if (c) begin
        m_new = 0;
        m_shadow.delete();
      end
      return;
    end
    if (e) begin
      m_entry.push_back(d);
      if (m_entry.size() == ND) begin
        ok = 1;
        for (int i = 0; i < ND; i++) if (m_entry[i] != m_code[i]) ok = 0;
        m_entry.delete();
        if (ok) begin
          m_open = 1;
          m_fails = 0;
          m_relock = RL;
        end else begin
          m_fails++;
          if (m_fails == MF) m_alarm = 1;
          else m_lock = LK;
        end
      end
    end else if (c) begin
      m_entry.delete();
    end
  endfunction

  function automatic int exp_status();
    int idx;
    int lk;
    if (m_new) idx = m_shadow.size();
    else if (!m_open && !m_alarm && m_lock == 0) idx = m_entry.size();
    else idx = 0;
    lk = (m_lock > 0) ? 1 : 0;
    return (int'(m_open) << 7) | (int'(m_new) << 6) | (int'(m_alarm) << 5) |
           (lk << 4) | (idx << 2) | m_fails;
  endfunction

  function automatic int dut_status();
    return int'({open, new_code, alarm, locked_out, digit_idx, fail_count});
  endfunction

  task automatic cycle(input bit en, input bit ch, input int d);
    @(negedge clock);
    enter_pulse  = en;
    change_pulse = ch;
    digit        = 4'(d);
    @(posedge clock);
    #1;
    model_step(en, ch, d & 15);
    chk("status", dut_status(), exp_status());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic enter3(input int a, input int b, input int c);
    cycle(1, 0, a);
    cycle(1, 0, b);
    cycle(1, 0, c);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    enter_pulse = 1'b0;
    change_pulse = 1'b0;
    digit = '0;
    #1;
    model_reset();
    chk("reset_status", dut_status(), exp_status());
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int r, d;
    bit en, ch;

    do_reset();
    chk("reset_literal", dut_status(), 0);

    // Correct default code opens.
    enter3(6, 6, 6);
    chk("open_after_666", int'(open), 1);
    chk("fc_after_open", int'(fail_count), 0);
    cycle(1, 0, 0);
    chk("relock_by_enter", int'(open), 0);

    // Wrong code: 100-cycle lockout, strobes ignored.
    enter3(6, 5, 6);
    chk("lockout_set", int'(locked_out), 1);
    chk("fc_one", int'(fail_count), 1);
    for (int i = 0; i < 99; i++) cycle((i % 7) == 0, 0, 6);
    chk("lockout_cycle_100", int'(locked_out), 1);
    chk("lockout_idx_stays", int'(digit_idx), 0);
    cycle(1, 0, 6);
    chk("lockout_released", int'(locked_out), 0);
    chk("lockout_idx_after", int'(digit_idx), 0);

    // Two more failures reach the alarm.
    enter3(1, 1, 1);
    idle(LK);
    enter3(2, 2, 2);
    chk("alarm_set", int'(alarm), 1);
    chk("alarm_fc_sat", int'(fail_count), MF);
    enter3(6, 6, 6);
    cycle(0, 1, 0);
    chk("alarm_sticky", int'(alarm), 1);
    chk("alarm_no_open", int'(open), 0);

    do_reset();
    chk("alarm_cleared", int'(alarm), 0);
    enter3(6, 6, 6);
    chk("default_restored", int'(open), 1);

    // Code change to 1,2,3.
    cycle(0, 1, 0);
    chk("change_new", int'(new_code), 1);
    cycle(1, 0, 1);
    cycle(1, 0, 2);
    chk("change_idx2", int'(digit_idx), 2);
    chk("change_new_mid", int'(new_code), 1);
    cycle(1, 0, 3);
    chk("change_done", int'(new_code), 0);
    enter3(6, 6, 6);
    chk("old_code_fails", int'(locked_out), 1);
    idle(LK);
    enter3(1, 2, 3);
    chk("new_code_opens", int'(open), 1);

    // Aborted change keeps the old code; reset mid-change restores default.
    do_reset();
    enter3(6, 6, 6);
    cycle(0, 1, 0);
    cycle(1, 0, 1);
    cycle(1, 0, 2);
    cycle(0, 1, 0);
    chk("abort_new", int'(new_code), 0);
    chk("abort_idx", int'(digit_idx), 0);
    enter3(6, 6, 6);
    chk("abort_keeps_code", int'(open), 1);

    cycle(1, 0, 0);
    cycle(1, 0, 6);
    cycle(1, 1, 6);
    chk("simul_ignored", int'(digit_idx), 1);
    cycle(0, 1, 0);
    chk("change_abandons", int'(digit_idx), 0);
    chk("abandon_no_fail", int'(fail_count), 0);

    enter3(6, 6, 6);
    cycle(0, 1, 0);
    cycle(1, 0, 7);
    cycle(1, 0, 7);
    do_reset();
    enter3(6, 6, 6);
    chk("reset_mid_change", int'(open), 1);

`ifdef SEQ_LOCK_AUTO_RELOCK_EN
    do_reset();
    enter3(6, 6, 6);
    idle(RL - 1);
    chk("relock_before", int'(open), 1);
    idle(1);
    chk("relock_expire", int'(open), 0);
    enter3(6, 6, 6);
    idle(299);
    cycle(1, 1, 0);
    idle(499);
    chk("relock_restart_hold", int'(open), 1);
    idle(1);
    chk("relock_restart_expire", int'(open), 0);
`endif

    // Random phase, biased toward the correct next digit.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 199));
      if (r < 2) begin
        do_reset();
      end else begin
        r  = int'($urandom_range(0, 99));
        en = (r < 35) || (r >= 97);
        ch = (r >= 92);
        d  = int'($urandom_range(0, 15));
        if (!m_new && m_entry.size() < ND && $urandom_range(0, 3) != 0)
          d = m_code[m_entry.size()];
        cycle(en, ch, d);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_lock.md
Name: seq_lock

Overview:
- Parametrised multi-digit combination lock.
- The user enters NUM_DIGITS digits one at a time, each strobed by enter_pulse; the whole sequence is checked after the last digit.
- Failed attempts trigger a timed lockout. Exhausting the attempt budget raises a sticky alarm.
- The code can be changed only from the open state.
- Sits behind the pushbutton input-conditioning pulsers and drives the status display decoder.

Parameters:
- DIGIT_W, 4, width of one digit (switch bank).
- NUM_DIGITS, 3, digits per code; must be >= 2.
- MAX_FAILS, 3, failed attempts before alarm; must be >= 1.
- LOCKOUT_CYCLES, 100, clock cycles the lock ignores input after a failed attempt.
- DEFAULT_CODE, {3{4'h6}}, NUM_DIGITS*DIGIT_W code loaded at reset; digit 0 is in the LSBs.
- RELOCK_CYCLES, 500, open-state timeout. Used only with AUTO_RELOCK_EN.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- digit  in  DIGIT_W  current digit value.
- enter_pulse  in  1  single-cycle strobe that captures digit.
- change_pulse  in  1  single-cycle strobe that requests or aborts a code change.
- open  out  1  high in OPEN.
- new  out  1  high in CHANGE.
- alarm  out  1  high in ALARM.
- locked_out  out  1  high in LOCKOUT.
- digit_idx  out  $clog2(NUM_DIGITS)  next digit position to be entered.
- fail_count  out  $clog2(MAX_FAILS+1)  failed attempts since the last successful open.

Behaviour:
- Reset values:
  - State = ENTRY; all status outputs 0.
  - digit_idx = 0; fail_count = 0; mismatch flag = 0.
  - Code store = DEFAULT_CODE; lockout/relock timers = 0.
- Registered Moore outputs, decoded from the state register. A transition is visible one cycle after the causing strobe.
- Strobe rules:
  - enter_pulse and change_pulse high in the same cycle: ignored in every state.
  - Strobes arriving in LOCKOUT or ALARM are discarded, not queued.
- ENTRY:
  - enter_pulse compares digit against code[digit_idx] and ORs any mismatch into a sticky flag.
  - digit_idx increments on each enter_pulse.
  - On the enter_pulse at digit_idx == NUM_DIGITS-1 (final digit):
    - Evaluate flag OR'd with this digit's mismatch.
    - Pass -> OPEN, fail_count = 0.
    - Fail with fail_count+1 == MAX_FAILS -> ALARM, fail_count saturates at MAX_FAILS.
    - Otherwise fail -> LOCKOUT, fail_count increments.
    - In all cases digit_idx = 0 and flag is cleared.
  - change_pulse in ENTRY: abandons the partial entry (digit_idx = 0, flag cleared). No fail is counted.
- LOCKOUT:
  - Counter loads LOCKOUT_CYCLES-1 on entry and counts down.
  - At 0 -> ENTRY.
- OPEN:
  - enter_pulse -> ENTRY (relock).
  - change_pulse -> CHANGE, digit_idx = 0.
- CHANGE:
  - enter_pulse writes digit into the shadow register at digit_idx; digit_idx increments.
  - After the final digit: shadow is committed to the code store in one cycle -> ENTRY.
  - change_pulse before completion aborts -> ENTRY. Code store is unchanged and shadow is discarded.
- ALARM: absorbing; left only by reset.
- Reset asserted mid-entry, mid-lockout or mid-change:
  - Returns to the reset values above, including DEFAULT_CODE.
  - No partial shadow commit.

Optional Feature:
- Macro: SEQ_LOCK_AUTO_RELOCK_EN.
- Defined: OPEN starts a RELOCK_CYCLES down-counter; expiry -> ENTRY. Any strobe restarts the counter, and enter_pulse/change_pulse still act as normal.
- Undefined: OPEN persists until enter_pulse or change_pulse. No counter logic is synthesised, and RELOCK_CYCLES is unused.

Decomposition:
- Shared package seq_lock_pkg holds:
  - state enum ENTRY, OPEN, CHANGE, LOCKOUT, ALARM (3-bit encoding);
  - default parameter constants;
  - a function returning the digit slice of a packed code.
- One sub-module: code_store.
  - Holds NUM_DIGITS x DIGIT_W registers plus the shadow register.
  - Combinational read port addressed by digit_idx.
  - Shadow write enable, and a commit strobe that copies shadow to code.
  - Async reset to DEFAULT_CODE.

Test Plan:
- Default params, reset, then enter 6,6,6 -> open=1 one cycle after the third enter; fail_count=0.
- Enter 6,5,6 -> locked_out=1 for exactly 100 cycles; fail_count=1; enter strobes during lockout are ignored (digit_idx stays 0).
- Three wrong sequences -> alarm=1 after the third; further strobes are ignored; reset clears alarm and restores code 6,6,6.
- Enter 6,6,6, then change, then 1,2,3 -> new=1 through entry, commit, ENTRY state; 6,6,6 now fails; 1,2,3 opens.
- In CHANGE after digits 1,2, change_pulse -> ENTRY; old code 6,6,6 still opens. Simultaneous enter+change in ENTRY -> no state or digit_idx change.
- With SEQ_LOCK_AUTO_RELOCK_EN: open, then idle 500 cycles -> open=0 at cycle 500. A strobe at cycle 300 delays relock to cycle 800.
